// File: rtl/divider_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : divider_sweep_ctrl
// Description : Steps the DDS divider ratio from start to stop in fixed
//               increments, dwelling a programmable number of divider periods
//               per point, then stops or loops.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_sweep_ctrl #(
    parameter int N_W     = 7,
    parameter int DWELL_W = 16,
    parameter int IDX_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [N_W-1:0]     cfg_start_n,
    input  logic [N_W-1:0]     cfg_stop_n,
    input  logic [N_W-1:0]     cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    input  logic               start,
    input  logic               abort,
    input  logic               div_period,
    output logic [N_W-1:0]     n_out,
    output logic               div_rst,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   sweep_idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [N_W-1:0]     c_MIN_N     = N_W'(2);
    localparam logic [N_W:0]       c_MIN_N_EXT = (N_W + 1)'(2);
    localparam logic [DWELL_W-1:0] c_DWELL_ONE = DWELL_W'(1);
    localparam logic [IDX_W-1:0]   c_IDX_ONE   = IDX_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_start_d;
    logic [N_W-1:0]     r_start_n;
    logic [N_W-1:0]     r_stop_n;
    logic [N_W-1:0]     r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_loop;
    logic               r_dir_up;
    logic [N_W-1:0]     r_n_out;
    logic [IDX_W-1:0]   r_idx;
    logic [DWELL_W-1:0] r_cnt;

    logic               w_cfg_fire;
    logic               w_start_rise;
    logic               w_dwell_end;
    logic [N_W:0]       w_nxt;
    logic               w_is_last;
    logic [N_W-1:0]     w_san_start;
    logic [N_W-1:0]     w_san_stop;

    // Ratios must be even and at least 2 for the divider to behave.
    function automatic logic [N_W-1:0] f_ratio(input logic [N_W-1:0] v);
        logic [N_W-1:0] t;
        t = {v[N_W-1:1], 1'b0};
        if (t < c_MIN_N) begin
            t = c_MIN_N;
        end
        return t;
    endfunction

    assign w_san_start  = f_ratio(cfg_start_n);
    assign w_san_stop   = f_ratio(cfg_stop_n);
    assign w_cfg_fire   = cfg_valid && cfg_ready;
    assign w_start_rise = start && !r_start_d;

    // r_cnt stays below r_dwell in RUN, so the increment cannot overflow.
    assign w_dwell_end  = (r_state == S_RUN) && div_period &&
                          ((r_cnt + c_DWELL_ONE) == r_dwell);

    always_comb begin
        w_nxt     = '0;
        w_is_last = 1'b0;
        if (r_dir_up) begin
            w_nxt     = {1'b0, r_n_out} + {1'b0, r_step};
            w_is_last = (w_nxt > {1'b0, r_stop_n});
        end else begin
            w_nxt     = {1'b0, r_n_out} - {1'b0, r_step};
            w_is_last = w_nxt[N_W] || (w_nxt < {1'b0, r_stop_n}) ||
                        (w_nxt < c_MIN_N_EXT);
        end
        if (r_step == '0) begin
            w_is_last = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        div_rst     = 1'b0;
        case (r_state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (w_start_rise) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy        = 1'b1;
                div_rst     = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_dwell_end && w_is_last && !r_loop) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                cfg_ready = 1'b1;
                done      = 1'b1;
                if (w_start_rise) begin
                    w_state_nxt = S_LOAD;
                end else if (w_cfg_fire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_d <= 1'b0;
            r_start_n <= '0;
            r_stop_n  <= '0;
            r_step    <= '0;
            r_dwell   <= '0;
            r_loop    <= 1'b0;
            r_dir_up  <= 1'b0;
        end else begin
            r_start_d <= start;
            if (w_cfg_fire) begin
                r_start_n <= w_san_start;
                r_stop_n  <= w_san_stop;
                r_step    <= {cfg_step[N_W-1:1], 1'b0};
                r_dwell   <= (cfg_dwell == '0) ? c_DWELL_ONE : cfg_dwell;
                r_loop    <= cfg_loop;
                r_dir_up  <= (w_san_start <= w_san_stop);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n_out <= c_MIN_N;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else if (abort) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_n_out <= r_start_n;
                    r_idx   <= '0;
                    r_cnt   <= '0;
                end
                S_RUN: begin
                    if (w_dwell_end) begin
                        r_cnt <= '0;
                        // New ratio lands with the terminating pulse so the
                        // divider switches exactly at its period boundary.
                        if (!w_is_last) begin
                            r_n_out <= w_nxt[N_W-1:0];
                            r_idx   <= r_idx + c_IDX_ONE;
                        end else if (r_loop) begin
                            r_n_out <= r_start_n;
                            r_idx   <= '0;
                        end
                    end else if (div_period) begin
                        r_cnt <= r_cnt + c_DWELL_ONE;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign n_out     = r_n_out;
    assign sweep_idx = r_idx;

endmodule
`default_nettype wire

// File: doc/divider_sweep_ctrl.md
Name: divider_sweep_ctrl

Overview:
- Sequencer that programs the ratio input `n` of the DDS clock divider.
- Steps `n` from a start value to a stop value (up or down) in fixed increments.
- Holds each point for a programmable number of divider output periods, then stops or loops.
- Loaded by the host control logic through a valid/ready config port; sits between the host registers and the divider.

Parameters:
- N_W, 7, width of divide ratio (matches divider `n` input)
- DWELL_W, 16, width of dwell counter (periods per point)
- IDX_W, 8, width of sweep point index

Ports:
- clk  in  1  system clock (same clock as divider)
- reset  in  1  asynchronous, active-high
- cfg_valid  in  1  config word present
- cfg_ready  out  1  controller accepts config (IDLE or DONE only)
- cfg_start_n  in  N_W  first divide ratio
- cfg_stop_n  in  N_W  last divide ratio bound
- cfg_step  in  N_W  ratio increment magnitude
- cfg_dwell  in  DWELL_W  divider periods per point
- cfg_loop  in  1  1 = restart at start_n after last point
- start  in  1  begin sweep (level sampled, acts on rising cycle)
- abort  in  1  stop immediately
- div_period  in  1  one-cycle pulse from divider, once per full output period
- n_out  out  N_W  ratio driven to divider
- div_rst  out  1  one-cycle reset pulse to divider
- busy  out  1  sweep in progress
- done  out  1  non-loop sweep finished (sticky)
- sweep_idx  out  IDX_W  index of current point, 0 = start_n

Behaviour:
- Reset values: n_out=2, div_rst=0, busy=0, done=0, cfg_ready=1, sweep_idx=0; all config registers 0; state IDLE.
- Ratio sanitising on capture:
  - LSB of start_n and stop_n cleared.
  - Values <2 forced to 2.
  - step LSB cleared; step 0 allowed.
  - dwell 0 treated as 1.
- Direction: up if start_n<=stop_n, else down; fixed at capture.
- Config handshake:
  - Transfer on cfg_valid&&cfg_ready; registers update next edge.
  - cfg_ready=0 in LOAD/RUN.
  - A transfer in DONE clears done and moves to IDLE.
- States:
  - IDLE: idle. start (with no abort) -> LOAD.
  - LOAD: one cycle.
    - n_out<=start_n, sweep_idx<=0, dwell counter<=0.
    - div_rst=1 for this cycle only.
    - busy=1. Next state RUN.
  - RUN: busy=1. Each div_period pulse increments the dwell counter.
    - On the pulse that makes count==dwell: counter<=0 and next point computed in N_W+1 bits.
    - Up: nxt=n_out+step. Down: nxt=n_out-step.
    - Last-point condition: step==0, OR up and nxt>stop_n, OR down and (nxt<stop_n or nxt<2 or borrow).
    - Not last: n_out<=nxt, sweep_idx++, same cycle as the terminating pulse, so the divider picks up the new ratio at its period boundary. No div_rst.
    - Last and cfg_loop=1: n_out<=start_n, sweep_idx<=0, stay RUN, no div_rst.
    - Last and cfg_loop=0: -> DONE; n_out held.
  - DONE: busy=0, done=1 (sticky), cfg_ready=1. start -> LOAD (done cleared on entry to LOAD).
- div_period outside RUN is ignored.
- abort: highest priority, any state.
  - Next cycle state IDLE, busy=0, done=0, dwell counter=0.
  - n_out and sweep_idx held.
  - Simultaneous start ignored.
- start while in LOAD/RUN is ignored (no restart).
- sweep_idx wraps modulo 2^IDX_W; no effect on sequencing.
- n_out changes only in LOAD, at a dwell-terminating div_period in RUN, or on reset.
- Reset mid-sweep: all outputs return to reset values asynchronously.

Test Plan:
- Up sweep: start_n=10, stop_n=16, step=2, dwell=3, loop=0, start.
  - div_rst pulses once; n_out=10,12,14,16, each held for 3 div_period pulses; sweep_idx 0..3.
  - done=1 and busy=0 one cycle after the 12th pulse.
- Down sweep with overshoot: start_n=20, stop_n=7 (sanitised to 6), step=6, dwell=1 -> n_out=20,14,8, then done; idx ends at 2.
- Loop and sanitising: start_n=5 (->4), stop_n=8, step=4, dwell=0 (->1), loop=1 -> n_out 4,8,4,8... per pulse; done never asserts; abort mid-run -> busy=0 next cycle, n_out holds last value.
- Handshake: cfg_valid during RUN -> cfg_ready=0, no capture; cfg_valid in DONE -> captured, done clears, state IDLE; start+abort same cycle in IDLE -> stays IDLE.
- Edge cases:
  - step=0, dwell=2 -> n_out=start_n, done after 2 pulses.
  - start_n=126, step=4, stop_n=126 -> done after dwell, no wrap to a small n.
- Async reset asserted mid-RUN between clock edges -> n_out=2, busy=0, done=0 immediately; no further activity until a new start.
